// File: rtl/ldpc_uart_rx.sv
// UART receiver for two 8N1 frames forming a 16-bit LDPC codeword {message, parity}.
// Computes the syndrome, corrects any single-bit error and reports decode status.
module ldpc_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [7:0]  message,
  output logic [15:0] corrected_codeword,
  output logic [7:0]  syndrome,
  output logic        rx_done,
  output logic        err_corrected,
  output logic        err_uncorrectable,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int TW   = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, DECODE} state_t;

  state_t          state_q, state_d;
  logic            rx_meta_q, rx_sync_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hi_q, hi_d;
  logic            byte_idx_q, byte_idx_d;
  logic [7:0]      msg_q, msg_d;
  logic [15:0]     cw_q, cw_d;
  logic [7:0]      syn_q, syn_d;
  logic            done_q, done_d;
  logic            corr_q, corr_d;
  logic            unc_q, unc_d;
  logic            ferr_q, ferr_d;

  logic [15:0]     raw_word;
  logic [7:0]      calc_parity;
  logic [7:0]      calc_syn;
  logic [7:0]      msg_flip;
  logic            par_hit;
  logic            fix_hit;
  logic [15:0]     fixed_word;

  function automatic logic [7:0] row(input int i);
    case (i)
      0:       return 8'h03;
      1:       return 8'h06;
      2:       return 8'h0C;
      3:       return 8'h18;
      4:       return 8'h30;
      5:       return 8'h60;
      6:       return 8'hC0;
      7:       return 8'h81;
      default: return 8'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Syndrome and single-bit correction of the stored word; rows are never one-hot, so hits are exclusive.
  assign raw_word = {hi_q, shift_q};

  always_comb begin
    calc_parity = 8'h00;
    msg_flip    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (raw_word[8+i]) calc_parity = calc_parity ^ row(i);
    end
    calc_syn = raw_word[7:0] ^ calc_parity;
    for (int i = 0; i < 8; i++) begin
      msg_flip[i] = (calc_syn == row(i));
    end
    par_hit    = (calc_syn != 8'h00) && ((calc_syn & (calc_syn - 8'd1)) == 8'h00);
    fix_hit    = par_hit || (msg_flip != 8'h00);
    fixed_word = {raw_word[15:8] ^ msg_flip, par_hit ? (raw_word[7:0] ^ calc_syn) : raw_word[7:0]};
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    hi_d       = hi_q;
    byte_idx_d = byte_idx_q;
    msg_d      = msg_q;
    cw_d       = cw_q;
    syn_d      = syn_q;
    corr_d     = corr_q;
    unc_d      = unc_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_sync_q) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == TW'(HALF - 1)) begin
          timer_d   = '0;
          bit_cnt_d = 3'd0;
          state_d   = rx_sync_q ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          timer_d   = '0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (timer_q == TW'(CLKS_PER_BIT - 1)) begin
          timer_d = '0;
          if (!rx_sync_q) begin
            ferr_d     = 1'b1;
            byte_idx_d = 1'b0;
            state_d    = IDLE;
          end else if (!byte_idx_q) begin
            hi_d       = shift_q;
            byte_idx_d = 1'b1;
            state_d    = IDLE;
          end else begin
            // Results are loaded on entry to DECODE so they are valid while rx_done is high.
            msg_d   = fixed_word[15:8];
            cw_d    = fixed_word;
            syn_d   = calc_syn;
            corr_d  = fix_hit;
            unc_d   = (calc_syn != 8'h00) && !fix_hit;
            done_d  = 1'b1;
            state_d = DECODE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DECODE: begin
        byte_idx_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      hi_q       <= 8'h00;
      byte_idx_q <= 1'b0;
      msg_q      <= 8'h00;
      cw_q       <= 16'h0000;
      syn_q      <= 8'h00;
      done_q     <= 1'b0;
      corr_q     <= 1'b0;
      unc_q      <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      hi_q       <= hi_d;
      byte_idx_q <= byte_idx_d;
      msg_q      <= msg_d;
      cw_q       <= cw_d;
      syn_q      <= syn_d;
      done_q     <= done_d;
      corr_q     <= corr_d;
      unc_q      <= unc_d;
      ferr_q     <= ferr_d;
    end
  end

  assign message            = msg_q;
  assign corrected_codeword = cw_q;
  assign syndrome           = syn_q;
  assign rx_done            = done_q;
  assign err_corrected      = corr_q;
  assign err_uncorrectable  = unc_q;
  assign frame_err          = ferr_q;
  assign rx_busy            = (state_q == DATA) || (state_q == STOP) || (state_q == DECODE);

endmodule

// File: tb/tb_ldpc_uart_rx.sv
// Bench for ldpc_uart_rx: serializes codewords onto rx and compares decoded results
// against a brute-force single-flip decoder model.
module tb_ldpc_uart_rx;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [7:0]  message;
  logic [15:0] corrected_codeword;
  logic [7:0]  syndrome;
  logic        rx_done, err_corrected, err_uncorrectable, frame_err, rx_busy;

  ldpc_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk                (clk),
    .rst                (rst),
    .rx                 (rx),
    .message            (message),
    .corrected_codeword (corrected_codeword),
    .syndrome           (syndrome),
    .rx_done            (rx_done),
    .err_corrected      (err_corrected),
    .err_uncorrectable  (err_uncorrectable),
    .frame_err          (frame_err),
    .rx_busy            (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rxWord;
    logic [7:0]  expMsg;
    logic [15:0] expCw;
    logic [7:0]  expSyn;
    logic        expCorr;
    logic        expUnc;
  } vec_t;

  vec_t vecs [8];

  int total = 0;
  int bad = 0;
  int doneCount = 0;
  int ferrCount = 0;
  int bothCount = 0;
  int busyCount = 0;
  logic capCorr = 1'b0;
  logic capUnc = 1'b0;

  // Pulse counters and flag capture, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_done) begin
      doneCount = doneCount + 1;
      capCorr   = err_corrected;
      capUnc    = err_uncorrectable;
    end
    if (frame_err) ferrCount = ferrCount + 1;
    if (rx_done && frame_err) bothCount = bothCount + 1;
    if (rx_busy) busyCount = busyCount + 1;
  end

  function automatic logic [7:0] modelRow(input int i);
    logic [15:0] t;
    t = 16'h0003 << i;
    return t[7:0] | t[15:8];
  endfunction

  function automatic logic [7:0] modelSyn(input logic [15:0] w);
    logic [7:0] s;
    s = w[7:0];
    for (int i = 0; i < 8; i++) if (w[8+i]) s = s ^ modelRow(i);
    return s;
  endfunction

  // Decoder model: search every single-bit flip for one that yields a valid codeword.
  task automatic modelDecode(input logic [15:0] w, output logic [15:0] cw, output logic [7:0] syn,
                             output logic corr, output logic unc);
    logic [15:0] t;
    syn  = modelSyn(w);
    cw   = w;
    corr = 1'b0;
    unc  = 1'b0;
    if (syn != 8'h00) begin
      for (int b = 0; b < 16; b++) begin
        t = w ^ (16'h0001 << b);
        if (modelSyn(t) == 8'h00) begin
          cw   = t;
          corr = 1'b1;
        end
      end
      unc = !corr;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stopOk);
    sendBit(1'b0, CPB);
    for (int k = 0; k < 8; k++) sendBit(data[k], CPB);
    if (stopOk) begin
      sendBit(1'b1, CPB);
    end else begin
      sendBit(1'b0, (CPB * 3) / 4);
      sendBit(1'b1, CPB / 4);
    end
  endtask

  task automatic sendWord(input logic [15:0] w, input int gap);
    applyStimulus(w[15:8], 1'b1);
    sendBit(1'b1, gap);
    applyStimulus(w[7:0], 1'b1);
  endtask

  task automatic waitDone(input int target, input string name);
    int n;
    n = 0;
    while (doneCount < target && n < 4 * CPB) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checkOutput({name, " rx_done count"}, 16'(doneCount), 16'(target));
  endtask

  task automatic checkWord(input string name, input logic [7:0] eMsg, input logic [15:0] eCw,
                           input logic [7:0] eSyn, input logic eCorr, input logic eUnc);
    checkOutput({name, " message"}, {8'h00, message}, {8'h00, eMsg});
    checkOutput({name, " codeword"}, corrected_codeword, eCw);
    checkOutput({name, " syndrome"}, {8'h00, syndrome}, {8'h00, eSyn});
    checkOutput({name, " err_corrected"}, {15'h0, capCorr}, {15'h0, eCorr});
    checkOutput({name, " err_uncorrectable"}, {15'h0, capUnc}, {15'h0, eUnc});
  endtask

  initial begin
    int d0, f0, b0;
    logic [15:0] w, eCw;
    logic [7:0] m, eSyn;
    logic eCorr, eUnc;
    int b1, b2, nflip;

    vecs[0] = '{16'hDD66, 8'hDD, 16'hDD66, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{16'hD566, 8'hDD, 16'hDD66, 8'h18, 1'b1, 1'b0};
    vecs[2] = '{16'hDD67, 8'hDD, 16'hDD66, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{16'hDE66, 8'hDE, 16'hDE66, 8'h05, 1'b0, 1'b1};
    vecs[4] = '{16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 8'hFF, 16'hFFFF, 8'hFF, 1'b0, 1'b1};
    vecs[6] = '{16'h0001, 8'h00, 16'h0000, 8'h01, 1'b1, 1'b0};
    vecs[7] = '{16'h0100, 8'h00, 16'h0000, 8'h03, 1'b1, 1'b0};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset message", {8'h00, message}, 16'h0);
    checkOutput("reset codeword", corrected_codeword, 16'h0);
    checkOutput("reset syndrome", {8'h00, syndrome}, 16'h0);
    checkOutput("reset rx_done", {15'h0, rx_done}, 16'h0);
    checkOutput("reset err_corrected", {15'h0, err_corrected}, 16'h0);
    checkOutput("reset err_uncorrectable", {15'h0, err_uncorrectable}, 16'h0);
    checkOutput("reset frame_err", {15'h0, frame_err}, 16'h0);
    checkOutput("reset rx_busy", {15'h0, rx_busy}, 16'h0);

    for (int i = 0; i < 8; i++) begin
      d0 = doneCount;
      b0 = busyCount;
      sendWord(vecs[i].rxWord, int'($urandom_range(0, CPB)));
      waitDone(d0 + 1, $sformatf("vec%0d", i));
      checkWord($sformatf("vec%0d", i), vecs[i].expMsg, vecs[i].expCw, vecs[i].expSyn,
                vecs[i].expCorr, vecs[i].expUnc);
      if (i == 0) checkOutput("busy seen during word", {15'h0, busyCount > b0}, 16'h1);
    end

    // One-cycle low glitch must not start a frame.
    d0 = doneCount;
    f0 = ferrCount;
    b0 = busyCount;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("glitch rx_done count", 16'(doneCount), 16'(d0));
    checkOutput("glitch frame_err count", 16'(ferrCount), 16'(f0));
    checkOutput("glitch busy cycles", 16'(busyCount), 16'(b0));

    // First frame with a low stop bit, then a clean word.
    d0 = doneCount;
    f0 = ferrCount;
    applyStimulus(8'hDD, 1'b0);
    sendBit(1'b1, 2 * CPB);
    checkOutput("stop err frame_err count", 16'(ferrCount), 16'(f0 + 1));
    checkOutput("stop err rx_done count", 16'(doneCount), 16'(d0));
    sendWord(16'hDD66, 3);
    waitDone(d0 + 1, "after ferr");
    checkWord("after ferr", 8'hDD, 16'hDD66, 8'h00, 1'b0, 1'b0);

    // Reset after a lone first frame discards it.
    applyStimulus(8'h12, 1'b1);
    sendBit(1'b1, CPB);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midreset message", {8'h00, message}, 16'h0);
    checkOutput("midreset codeword", corrected_codeword, 16'h0);
    checkOutput("midreset syndrome", {8'h00, syndrome}, 16'h0);
    d0 = doneCount;
    sendWord(16'hDD66, 0);
    waitDone(d0 + 1, "post reset");
    checkWord("post reset", 8'hDD, 16'hDD66, 8'h00, 1'b0, 1'b0);

    for (int r = 0; r < 24; r++) begin
      m = 8'($urandom);
      w = {m, modelSyn({m, 8'h00})};
      nflip = int'($urandom_range(0, 2));
      b1 = int'($urandom_range(0, 15));
      b2 = (b1 + int'($urandom_range(1, 15))) % 16;
      if (nflip >= 1) w = w ^ (16'h0001 << b1);
      if (nflip == 2) w = w ^ (16'h0001 << b2);
      modelDecode(w, eCw, eSyn, eCorr, eUnc);
      d0 = doneCount;
      sendWord(w, int'($urandom_range(0, CPB)));
      waitDone(d0 + 1, $sformatf("rand%0d", r));
      checkWord($sformatf("rand%0d %h", r, w), eCw[15:8], eCw, eSyn, eCorr, eUnc);
    end

    checkOutput("rx_done with frame_err", 16'(bothCount), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ldpc_uart_rx.md
# ldpc_uart_rx

Receive-side endpoint of the UART+LDPC link. Deserializes two 8N1 UART frames from `rx` into a 16-bit systematic codeword, computes the 8-bit syndrome, corrects any single-bit error, and presents the decoded message byte with status. It sits at the far end of the serial line from the LDPC encoder/UART transmitter and is loopback-testable against it (`rx = tx`).

## Interface
- `CLKS_PER_BIT`, 868 — clk cycles per UART bit (115200 baud @ 100 MHz); must be ≥ 4.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `message`  out  8  decoded (corrected) message byte.
- `corrected_codeword`  out  16  `{message, parity}` after correction.
- `syndrome`  out  8  syndrome of the received codeword.
- `rx_done`  out  1  one-cycle pulse; all decode outputs are valid on this cycle.
- `err_corrected`  out  1  a single-bit error was corrected; valid with `rx_done`.
- `err_uncorrectable`  out  1  syndrome matches no single-bit pattern; valid with `rx_done`.
- `frame_err`  out  1  one-cycle pulse when a stop bit samples low.
- `rx_busy`  out  1  high from start-bit validation to end of frame/decode.

## Operation
- Codeword layout: bits [15:8] = message m, bits [7:0] = parity p.
- Parity row R(i) is the contribution of m[i]:
  - R0=8'h03, R1=8'h06, R2=8'h0C, R3=8'h18
  - R4=8'h30, R5=8'h60, R6=8'hC0, R7=8'h81
- Parity and syndrome:
  - P(m) = XOR of R(i) over every i with m[i]=1.
  - syndrome = p_rx XOR P(m_rx).
- Correction:
  - syndrome == 0: no error.
  - syndrome one-hot at bit j: flip p_rx[j]; set err_corrected.
  - syndrome == R(i): flip m_rx[i]; set err_corrected.
  - Any other syndrome: outputs carry the raw received word; set err_uncorrectable.
- `rx` passes through a 2-flop synchronizer; all sampling uses the synchronized value.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
  - First frame carries codeword[15:8].
  - Second frame carries codeword[7:0].
- Receiver states:
  - IDLE: wait for synchronized `rx` = 0, then go to START and clear the bit timer.
  - START: after CLKS_PER_BIT/2 cycles, sample. If 0, go to DATA. If 1 (glitch), return to IDLE with no other effect.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit) into a shift register; after 8 bits, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample is 1 and this is byte 0: store byte, set byte index to 1, go to IDLE.
    - Sample is 1 and this is byte 1: go to DECODE.
    - Sample is 0: pulse `frame_err`, discard any partial codeword, reset byte index to 0, go to IDLE.
  - DECODE: one cycle. Register outputs, pulse `rx_done`, reset byte index to 0, go to IDLE.
- Outputs hold their values until the next DECODE.
- `rst` in any state returns to IDLE with byte index 0; a partial codeword is discarded.

## Timing
- Reset values:
  - `message`, `corrected_codeword`, `syndrome`: 0.
  - `rx_done`, `err_corrected`, `err_uncorrectable`, `frame_err`, `rx_busy`: 0.
  - Synchronizer flops: 1.
- Sampling points, relative to the synchronized falling edge of the start bit:
  - Start bit: +CLKS_PER_BIT/2.
  - Data bit k (k = 0..7): +CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT.
  - Stop bit: +CLKS_PER_BIT/2 + 9·CLKS_PER_BIT.
- Pin-to-sample delay is 2 cycles (synchronizer).
- `rx_done` asserts exactly 1 cycle after the second frame's stop-bit sample. Syndrome and correction are combinational from the stored word and registered in DECODE.
- The next start bit may begin at the mid-point of the previous stop bit; the receiver is back in IDLE by then.
- No inter-frame timeout. A lone first frame stays pending until the second frame arrives, a frame error occurs, or `rst` is asserted.
- `frame_err` and `rx_done` are never high in the same cycle.

## Test plan
- Clean word: m=8'hDD, so p=8'h66 and the wire carries 16'hDD66 → `rx_done` pulse with `message`=8'hDD, `corrected_codeword`=16'hDD66, `syndrome`=8'h00, both error flags 0.
- Message bit error: send 16'hD566 (m[3] flipped) → `syndrome`=8'h18, `message`=8'hDD, `corrected_codeword`=16'hDD66, `err_corrected`=1.
- Parity bit error: send 16'hDD67 → `syndrome`=8'h01, `corrected_codeword`=16'hDD66, `err_corrected`=1.
- Double error: send 16'hDE66 (m[0] and m[1] flipped) → `syndrome`=8'h05, `err_uncorrectable`=1, `message`=8'hDE.
- Framing/glitch:
  - A 1-cycle low pulse on `rx` → no state change.
  - First frame with stop bit = 0 → `frame_err` pulse and no `rx_done`; a following clean 16'hDD66 then decodes correctly.
- Reset mid-operation: assert `rst` after the first frame is received → all outputs return to 0; a subsequent full 16'hDD66 decodes to `message`=8'hDD.
